mc_controller: RTL
==================

# mc_controller

Multi-cycle sequencing controller for the MIPS-subset datapath. It replaces the single-cycle decode path: it walks each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB and emits per-cycle write strobes and mux selects. It shares one unified memory port between instruction fetch and data access through a ready handshake. It sits between the instruction register and the register file, ALU, PC and memory port.

## Interface
- No parameters.
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], stable from DECODE onward
- funct  in  6  IR[5:0]
- zero, overflow  in  1 each  ALU flags, valid in EXEC
- mem_ready  in  1  memory completes the current access at this edge
- pc_wr, ir_wr, regwr  out  1 each  one-cycle write strobes
- memrd, memwr  out  1 each  memory request, held until mem_ready
- iord  out  1  memory address source: 0 = PC, 1 = ALU-out register
- regdst, alusrc, memtoreg, extop  out  1 each  datapath selects
- pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- aluctr  out  3  000 ADDU, 001 SUBU, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 SLT
- state  out  3  current state, for debug
- ovf_trap  out  1  one-cycle pulse: overflow write suppressed
- halted  out  1  sticky illegal-opcode stop

## Operation
- Supported opcodes:
  - R-type = 000000, with funct add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, slt 101010.
  - addi 001000, addiu 001001, ori 001101, lw 100011, sw 101011, beq 000100, j 000010.
- IDLE: all outputs 0. Goes to FETCH.
- FETCH: memrd=1, iord=0. On mem_ready: ir_wr=1, pc_wr=1, pc_sel=00, then DECODE. Otherwise stay.
- DECODE: no strobes. Goes to EXEC.
- EXEC: aluctr, alusrc and extop are driven per opcode.
  - R/addi/addiu/ori go to WB.
  - lw/sw go to MEM.
  - beq: pc_wr=zero, pc_sel=01, then FETCH.
  - j: pc_wr=1, pc_sel=10, then FETCH.
  - add/sub/addi with overflow=1: ovf_trap=1 and go to FETCH, skipping WB.
  - addu/subu/addiu never trap.
- MEM: iord=1.
  - lw: memrd held until mem_ready, then WB.
  - sw: memwr held until mem_ready, then FETCH.
- WB: regwr=1. regdst=1 for R-type. memtoreg=1 for lw. Goes to FETCH.
- Selects: extop=1 (sign) for addi/addiu/lw/sw/beq, 0 for ori. alusrc=1 for I-type ALU and lw/sw. beq uses SUBU.
- Unsupported funct under R-type is handled as an illegal opcode.
- Only one of memrd/memwr is asserted at a time. A request is never withdrawn before mem_ready, except by reset.

## Timing
- Reset asserted: state=IDLE immediately. Every output is 0, including halted.
- First rising edge after reset is released: IDLE→FETCH.
- All outputs are Moore/decode functions of state and IR fields. pc_wr in beq depends combinationally on zero.
- Cycles per instruction, zero-wait memory, counted FETCH to next FETCH:
  - beq, j: 3
  - R-type, I-type ALU, sw: 4
  - lw: 5
- Each memory wait cycle adds 1.
- mem_ready is ignored outside FETCH/MEM.
- Reset asserted mid-MEM: memrd/memwr drop asynchronously, no strobe is emitted, and the controller restarts at IDLE.

## Configuration
- MC_CTRL_ILLEGAL_TRAP_EN defined:
  - An illegal opcode/funct seen in DECODE goes to HALT (state 110).
  - In HALT all strobes are 0 and halted=1; only reset exits.
- Undefined:
  - Illegal instructions execute as NOPs: DECODE→EXEC→FETCH, no strobes.
  - halted is tied to 0.

## Structure
- Package mc_pkg holds:
  - opcode and funct constants
  - aluctr codes and pc_sel codes
  - state encodings: IDLE 000, FETCH 001, DECODE 010, EXEC 011, MEM 100, WB 101, HALT 110
- Sub-module mc_inst_decoder is combinational. It maps opcode/funct to aluctr, regdst, alusrc, extop, memtoreg, class (rtype/imm/load/store/branch/jump), ovf_trap_able and illegal.
- mc_controller holds the state register and the strobe logic.

## Test plan
- Reset low 3 cycles, then released → state=000 with all outputs 0; next cycle state=001, memrd=1, iord=0.
- add (funct 100000), mem_ready tied 1 → FETCH→DECODE→EXEC→WB in 4 cycles; aluctr=010; regwr=1 only in WB with regdst=1.
- lw with mem_ready low 3 cycles in MEM → memrd and iord=1 held 4 cycles; WB has memtoreg=1, regwr=1; 8 cycles total.
- beq with zero=1, then beq with zero=0 → pc_wr=1 with pc_sel=01 in EXEC for the first, pc_wr=0 for the second; both return to FETCH after 3 cycles.
- addi with overflow=1 in EXEC → ovf_trap pulses 1 cycle, no regwr, next state FETCH. Same with addiu → WB with regwr=1.
- opcode 111111: with the macro → state 110, halted=1 until reset. Without the macro → 3-cycle NOP.
- Reset asserted during a sw MEM wait → memwr falls with no clock edge; no regwr or pc_wr is seen.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS-subset controller: opcodes, functs,
// ALU/PC select codes, state and instruction-class encodings.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_SUBU = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_FETCH  = 3'b001,
    ST_DECODE = 3'b010,
    ST_EXEC   = 3'b011,
    ST_MEM    = 3'b100,
    ST_WB     = 3'b101,
    ST_HALT   = 3'b110
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_RTYPE,
    CLS_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP
  } cls_e;

endpackage

// File: rtl/mc_inst_decoder.sv
// Combinational opcode/funct decode into datapath selects and instruction class.
module mc_inst_decoder
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] aluctr,
  output logic       regdst,
  output logic       alusrc,
  output logic       extop,
  output logic       memtoreg,
  output cls_e       cls,
  output logic       ovf_trap_able,
  output logic       illegal
);

  always_comb begin
    aluctr        = ALU_ADDU;
    regdst        = 1'b0;
    alusrc        = 1'b0;
    extop         = 1'b0;
    memtoreg      = 1'b0;
    cls           = CLS_NONE;
    ovf_trap_able = 1'b0;
    illegal       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls    = CLS_RTYPE;
        regdst = 1'b1;
        case (funct)
          FN_ADD:  begin aluctr = ALU_ADD; ovf_trap_able = 1'b1; end
          FN_ADDU: aluctr = ALU_ADDU;
          FN_SUB:  begin aluctr = ALU_SUB; ovf_trap_able = 1'b1; end
          FN_SUBU: aluctr = ALU_SUBU;
          FN_AND:  aluctr = ALU_AND;
          FN_OR:   aluctr = ALU_OR;
          FN_SLT:  aluctr = ALU_SLT;
          default: begin
            cls     = CLS_NONE;
            regdst  = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        cls = CLS_IMM; aluctr = ALU_ADD; alusrc = 1'b1; extop = 1'b1;
        ovf_trap_able = 1'b1;
      end
      OP_ADDIU: begin cls = CLS_IMM; aluctr = ALU_ADDU; alusrc = 1'b1; extop = 1'b1; end
      OP_ORI:   begin cls = CLS_IMM; aluctr = ALU_OR; alusrc = 1'b1; end
      OP_LW: begin
        cls = CLS_LOAD; aluctr = ALU_ADDU; alusrc = 1'b1; extop = 1'b1; memtoreg = 1'b1;
      end
      OP_SW:    begin cls = CLS_STORE; aluctr = ALU_ADDU; alusrc = 1'b1; extop = 1'b1; end
      OP_BEQ:   begin cls = CLS_BRANCH; aluctr = ALU_SUBU; extop = 1'b1; end
      OP_J:     cls = CLS_JUMP;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle sequencing controller (IDLE/FETCH/DECODE/EXEC/MEM/WB) sharing one memory port.
// Build option: MC_CTRL_ILLEGAL_TRAP_EN routes illegal instructions to a sticky HALT state.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       regwr,
  output logic       memrd,
  output logic       memwr,
  output logic       iord,
  output logic       regdst,
  output logic       alusrc,
  output logic       memtoreg,
  output logic       extop,
  output logic [1:0] pc_sel,
  output logic [2:0] aluctr,
  output logic [2:0] state,
  output logic       ovf_trap,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [2:0] dec_aluctr;
  logic       dec_regdst, dec_alusrc, dec_extop, dec_memtoreg;
  logic       dec_ovf_able, dec_illegal;
  cls_e       dec_cls;

  mc_inst_decoder u_dec (
    .opcode        (opcode),
    .funct         (funct),
    .aluctr        (dec_aluctr),
    .regdst        (dec_regdst),
    .alusrc        (dec_alusrc),
    .extop         (dec_extop),
    .memtoreg      (dec_memtoreg),
    .cls           (dec_cls),
    .ovf_trap_able (dec_ovf_able),
    .illegal       (dec_illegal)
  );

  // Outputs decode from state_q, so an asynchronous reset drops any pending request at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    regwr    = 1'b0;
    memrd    = 1'b0;
    memwr    = 1'b0;
    iord     = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    extop    = 1'b0;
    pc_sel   = PC_PLUS4;
    aluctr   = ALU_ADDU;
    ovf_trap = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        memrd = 1'b1;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        state_d = dec_illegal ? ST_HALT : ST_EXEC;
`else
        state_d = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (!dec_illegal) begin
          aluctr = dec_aluctr;
          alusrc = dec_alusrc;
          extop  = dec_extop;
          case (dec_cls)
            CLS_RTYPE, CLS_IMM: begin
              if (dec_ovf_able && overflow) ovf_trap = 1'b1;
              else                          state_d  = ST_WB;
            end
            CLS_LOAD, CLS_STORE: state_d = ST_MEM;
            CLS_BRANCH: begin pc_wr = zero; pc_sel = PC_BRANCH; end
            CLS_JUMP:   begin pc_wr = 1'b1; pc_sel = PC_JUMP;   end
            default: ;
          endcase
        end
      end
      ST_MEM: begin
        iord  = 1'b1;
        memrd = (dec_cls == CLS_LOAD);
        memwr = (dec_cls == CLS_STORE);
        if (mem_ready || !(memrd || memwr))
          state_d = memrd ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        regwr    = 1'b1;
        regdst   = dec_regdst;
        memtoreg = dec_memtoreg;
        state_d  = ST_FETCH;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

  assign state = state_q;

endmodule
